bus_arbiter: RTL and testbench

- Shares the single system bus port between two masters: the core memory interface (master 0, "core") and the debug module's system-bus access engine (master 1, "dbg").
- Arbitrates per transaction and registers the winning request onto the slave side.
- Returns the response only to the owner.
- Provides a debug bus lock and a per-transaction response timeout, so a dead target cannot hang the core or the debugger.

---
 rtl/bus_arbiter.sv | 156 +++++++++++++++
 tb/tb_bus_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-master arbiter for the single system bus port: core (master 0) and debug SBA (master 1).
// Round-robin per-transaction grant, debug bus lock, registered slave request and response timeout.
module bus_arbiter #(
   parameter int AddrWidth     = 32,
   parameter int DataWidth     = 32,
   parameter int TimeoutCycles = 1024
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   core_req,
   input  logic                   core_wr,
   input  logic [AddrWidth-1:0]   core_addr,
   input  logic [DataWidth-1:0]   core_wdata,
   input  logic [DataWidth/8-1:0] core_be,
   output logic [DataWidth-1:0]   core_rdata,
   output logic                   core_ack,
   output logic                   core_err,
   input  logic                   dbg_req,
   input  logic                   dbg_wr,
   input  logic [AddrWidth-1:0]   dbg_addr,
   input  logic [DataWidth-1:0]   dbg_wdata,
   input  logic [DataWidth/8-1:0] dbg_be,
   input  logic                   dbg_lock,
   output logic [DataWidth-1:0]   dbg_rdata,
   output logic                   dbg_ack,
   output logic                   dbg_err,
   output logic                   s_req,
   output logic                   s_wr,
   output logic [AddrWidth-1:0]   s_addr,
   output logic [DataWidth-1:0]   s_wdata,
   output logic [DataWidth/8-1:0] s_be,
   input  logic [DataWidth-1:0]   s_rdata,
   input  logic                   s_ack,
   input  logic                   s_err,
   output logic                   owner_dbg,
   output logic                   timeout
);

   localparam int CntWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
   localparam logic [CntWidth-1:0] CntLast =
      CntWidth'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic                   owner_q, owner_d;       // 1 = dbg
   logic                   last_owner_q, last_owner_d;
   logic [CntWidth-1:0]    cnt_q, cnt_d;
   logic                   s_wr_q, s_wr_d;
   logic [AddrWidth-1:0]   s_addr_q, s_addr_d;
   logic [DataWidth-1:0]   s_wdata_q, s_wdata_d;
   logic [DataWidth/8-1:0] s_be_q, s_be_d;
   logic [DataWidth-1:0]   core_rdata_q, core_rdata_d;
   logic [DataWidth-1:0]   dbg_rdata_q, dbg_rdata_d;

   logic busy, resp, expire, done_ok, done_err;
   logic core_elig, dbg_elig, grant_dbg;

   // A locked bus with dbg as last owner keeps core out of arbitration entirely.
   assign core_elig = core_req & ~(dbg_lock & last_owner_q);
   assign dbg_elig  = dbg_req;
   assign grant_dbg = dbg_elig & (~core_elig | ~last_owner_q);

   assign busy   = (state_q == BUSY);
   assign resp   = busy & (s_ack | s_err);
   assign expire = busy & ~resp & (TimeoutCycles != 0) & (cnt_q == CntLast);

   // Responses seen while reset is asserted are discarded.
   assign done_ok  = busy & s_ack & ~s_err & ~rst;
   assign done_err = busy & (s_err | expire) & ~rst;

   assign core_ack  = done_ok  & ~owner_q;
   assign core_err  = done_err & ~owner_q;
   assign dbg_ack   = done_ok  &  owner_q;
   assign dbg_err   = done_err &  owner_q;
   assign timeout   = expire & ~rst;

   assign core_rdata = (resp & ~owner_q & ~rst) ? s_rdata : core_rdata_q;
   assign dbg_rdata  = (resp &  owner_q & ~rst) ? s_rdata : dbg_rdata_q;

   assign owner_dbg = (busy & owner_q) | (dbg_lock & last_owner_q);

   assign s_req   = busy;
   assign s_wr    = s_wr_q;
   assign s_addr  = s_addr_q;
   assign s_wdata = s_wdata_q;
   assign s_be    = s_be_q;

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      cnt_d        = cnt_q;
      s_wr_d       = s_wr_q;
      s_addr_d     = s_addr_q;
      s_wdata_d    = s_wdata_q;
      s_be_d       = s_be_q;
      core_rdata_d = core_rdata_q;
      dbg_rdata_d  = dbg_rdata_q;
      case (state_q)
         IDLE: begin
            if (core_elig | dbg_elig) begin
               state_d      = BUSY;
               owner_d      = grant_dbg;
               last_owner_d = grant_dbg;
               cnt_d        = '0;
               s_wr_d       = grant_dbg ? dbg_wr    : core_wr;
               s_addr_d     = grant_dbg ? dbg_addr  : core_addr;
               s_wdata_d    = grant_dbg ? dbg_wdata : core_wdata;
               s_be_d       = grant_dbg ? dbg_be    : core_be;
            end
         end
         BUSY: begin
            if (resp | expire) begin
               state_d = IDLE;
               cnt_d   = '0;
               if (resp && owner_q)  dbg_rdata_d  = s_rdata;
               if (resp && !owner_q) core_rdata_d = s_rdata;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b0;
         cnt_q        <= '0;
         s_wr_q       <= 1'b0;
         s_addr_q     <= '0;
         s_wdata_q    <= '0;
         s_be_q       <= '0;
         core_rdata_q <= '0;
         dbg_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         cnt_q        <= cnt_d;
         s_wr_q       <= s_wr_d;
         s_addr_q     <= s_addr_d;
         s_wdata_q    <= s_wdata_d;
         s_be_q       <= s_be_d;
         core_rdata_q <= core_rdata_d;
         dbg_rdata_q  <= dbg_rdata_d;
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios with fixed expectations, then randomized traffic
// checked cycle by cycle against a transaction-level model of the arbitration rules.
module tb_bus_arbiter;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        core_req, core_wr;
   logic [31:0] core_addr, core_wdata, core_rdata;
   logic [3:0]  core_be;
   logic        core_ack, core_err;
   logic        dbg_req, dbg_wr, dbg_lock;
   logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
   logic [3:0]  dbg_be;
   logic        dbg_ack, dbg_err;
   logic        s_req, s_wr;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic [3:0]  s_be;
   logic        s_ack, s_err;
   logic        owner_dbg, timeout;

   int tests_run    = 0;
   int tests_failed = 0;

   bus_arbiter #(.AddrWidth(32), .DataWidth(32), .TimeoutCycles(TO)) dut (
      .clk(clk), .rst(rst),
      .core_req(core_req), .core_wr(core_wr), .core_addr(core_addr),
      .core_wdata(core_wdata), .core_be(core_be), .core_rdata(core_rdata),
      .core_ack(core_ack), .core_err(core_err),
      .dbg_req(dbg_req), .dbg_wr(dbg_wr), .dbg_addr(dbg_addr),
      .dbg_wdata(dbg_wdata), .dbg_be(dbg_be), .dbg_lock(dbg_lock),
      .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack), .dbg_err(dbg_err),
      .s_req(s_req), .s_wr(s_wr), .s_addr(s_addr), .s_wdata(s_wdata), .s_be(s_be),
      .s_rdata(s_rdata), .s_ack(s_ack), .s_err(s_err),
      .owner_dbg(owner_dbg), .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      core_req = 0; core_wr = 0; core_addr = 0; core_wdata = 0; core_be = 0;
      dbg_req = 0; dbg_wr = 0; dbg_addr = 0; dbg_wdata = 0; dbg_be = 0; dbg_lock = 0;
      s_rdata = 0; s_ack = 0; s_err = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1;
      step(); step();
      @(negedge clk);
      tests_run++; if (s_req !== 1'b0) begin tests_failed++; $display("FAIL reset_s_req got=%b exp=0", s_req); end
      tests_run++; if ({core_ack, core_err, dbg_ack, dbg_err, timeout, owner_dbg} !== 6'b0) begin
         tests_failed++; $display("FAIL reset_pulses got=%b exp=000000", {core_ack, core_err, dbg_ack, dbg_err, timeout, owner_dbg}); end
      tests_run++; if ({core_rdata, dbg_rdata} !== 64'h0) begin
         tests_failed++; $display("FAIL reset_rdata got=%h/%h exp=0/0", core_rdata, dbg_rdata); end
      step();
      rst = 0;
      $display("[TB] reset checked");
   endtask

   task automatic test_round_robin();
      logic [31:0] exp_addr [4];
      exp_addr[0] = 32'hD0; exp_addr[1] = 32'hC0; exp_addr[2] = 32'hD0; exp_addr[3] = 32'hC0;
      for (int r = 0; r < 2; r++) begin
         step(); core_req = 1; core_addr = 32'hC0; dbg_req = 1; dbg_addr = 32'hD0;
         for (int k = 0; k < 2; k++) begin
            step(); s_ack = 1; s_rdata = 32'h100 + 32'(r * 2 + k);
            @(negedge clk);
            tests_run++; if (s_req !== 1'b1 || s_addr !== exp_addr[r*2+k]) begin
               tests_failed++; $display("FAIL rr_grant%0d got req=%b addr=%h exp req=1 addr=%h", r*2+k, s_req, s_addr, exp_addr[r*2+k]); end
            tests_run++; if ({core_ack, dbg_ack} !== ((k == 0) ? 2'b01 : 2'b10)) begin
               tests_failed++; $display("FAIL rr_ack%0d got core=%b dbg=%b", r*2+k, core_ack, dbg_ack); end
            step(); s_ack = 0;
            if (k == 0) dbg_req = 0; else core_req = 0;
         end
         $display("[TB] round robin pass %0d done", r);
      end
   endtask

   task automatic test_core_read();
      idle_inputs();
      step(); core_req = 1; core_addr = 32'h100; core_wr = 0;
      @(negedge clk);
      tests_run++; if (s_req !== 1'b0) begin tests_failed++; $display("FAIL cr_c0_s_req got=%b exp=0", s_req); end
      step();
      @(negedge clk);
      tests_run++; if (s_req !== 1'b1 || s_addr !== 32'h100 || s_wr !== 1'b0) begin
         tests_failed++; $display("FAIL cr_c1 got req=%b addr=%h wr=%b exp 1/100/0", s_req, s_addr, s_wr); end
      step();
      @(negedge clk);
      tests_run++; if (s_req !== 1'b1 || core_ack !== 1'b0) begin
         tests_failed++; $display("FAIL cr_c2 got req=%b ack=%b exp 1/0", s_req, core_ack); end
      step(); s_ack = 1; s_rdata = 32'hDEADBEEF;
      @(negedge clk);
      tests_run++; if (core_ack !== 1'b1 || core_rdata !== 32'hDEADBEEF || dbg_ack !== 1'b0 || s_req !== 1'b1) begin
         tests_failed++; $display("FAIL cr_c3 got ack=%b rdata=%h dbg_ack=%b exp 1/deadbeef/0", core_ack, core_rdata, dbg_ack); end
      step(); s_ack = 0; s_rdata = 32'h0; core_req = 0;
      @(negedge clk);
      tests_run++; if (s_req !== 1'b0 || core_ack !== 1'b0 || core_rdata !== 32'hDEADBEEF) begin
         tests_failed++; $display("FAIL cr_c4 got req=%b ack=%b rdata=%h exp 0/0/deadbeef", s_req, core_ack, core_rdata); end
      $display("[TB] core read 0x100 done");
   endtask

   task automatic test_lock();
      idle_inputs();
      for (int i = 0; i < 3; i++) begin
         step(); dbg_lock = 1; core_req = 1; core_addr = 32'hC4; core_wr = 0;
         dbg_req = 1; dbg_wr = 1; dbg_addr = 32'hA0 + 32'(4 * i); dbg_wdata = 32'h5A00 + 32'(i); dbg_be = 4'hF;
         @(negedge clk);
         tests_run++; if (s_req !== 1'b0 || owner_dbg !== (i > 0)) begin
            tests_failed++; $display("FAIL lock_grant%0d got req=%b odbg=%b exp 0/%0d", i, s_req, owner_dbg, i > 0); end
         step(); s_ack = 1;
         @(negedge clk);
         tests_run++; if (s_req !== 1'b1 || s_addr !== dbg_addr || s_wr !== 1'b1 || s_wdata !== dbg_wdata || owner_dbg !== 1'b1) begin
            tests_failed++; $display("FAIL lock_busy%0d got addr=%h wr=%b wdata=%h odbg=%b exp %h/1/%h/1", i, s_addr, s_wr, s_wdata, owner_dbg, dbg_addr, dbg_wdata); end
         tests_run++; if ({dbg_ack, core_ack} !== 2'b10) begin
            tests_failed++; $display("FAIL lock_ack%0d got dbg=%b core=%b exp 1/0", i, dbg_ack, core_ack); end
         step(); s_ack = 0; dbg_req = 0;
         @(negedge clk);
         tests_run++; if (s_req !== 1'b0 || owner_dbg !== 1'b1) begin
            tests_failed++; $display("FAIL lock_idle%0d got req=%b odbg=%b exp 0/1", i, s_req, owner_dbg); end
      end
      step(); dbg_lock = 0;
      @(negedge clk);
      tests_run++; if (s_req !== 1'b0 || owner_dbg !== 1'b0) begin
         tests_failed++; $display("FAIL lock_release got req=%b odbg=%b exp 0/0", s_req, owner_dbg); end
      step(); s_ack = 1;
      @(negedge clk);
      tests_run++; if (s_req !== 1'b1 || s_addr !== 32'hC4 || core_ack !== 1'b1 || owner_dbg !== 1'b0) begin
         tests_failed++; $display("FAIL lock_core got req=%b addr=%h ack=%b odbg=%b exp 1/c4/1/0", s_req, s_addr, core_ack, owner_dbg); end
      step(); s_ack = 0; core_req = 0;
      $display("[TB] lock sequence done");
   endtask

   task automatic test_timeout();
      idle_inputs();
      step(); core_req = 1; core_addr = 32'h200;
      for (int k = 1; k < TO; k++) begin
         step();
         @(negedge clk);
         tests_run++; if (s_req !== 1'b1 || core_err !== 1'b0 || timeout !== 1'b0) begin
            tests_failed++; $display("FAIL to_wait%0d got req=%b err=%b to=%b exp 1/0/0", k, s_req, core_err, timeout); end
      end
      step();
      @(negedge clk);
      tests_run++; if (core_err !== 1'b1 || timeout !== 1'b1 || core_ack !== 1'b0 || dbg_err !== 1'b0) begin
         tests_failed++; $display("FAIL to_expire got err=%b to=%b ack=%b dbg_err=%b exp 1/1/0/0", core_err, timeout, core_ack, dbg_err); end
      step(); core_req = 0;
      @(negedge clk);
      tests_run++; if (s_req !== 1'b0 || timeout !== 1'b0) begin
         tests_failed++; $display("FAIL to_drop got req=%b to=%b exp 0/0", s_req, timeout); end
      step(); core_req = 1; core_addr = 32'h204;
      step(); s_ack = 1;
      @(negedge clk);
      tests_run++; if (s_req !== 1'b1 || s_addr !== 32'h204 || core_ack !== 1'b1 || timeout !== 1'b0) begin
         tests_failed++; $display("FAIL to_next got req=%b addr=%h ack=%b exp 1/204/1", s_req, s_addr, core_ack); end
      step(); s_ack = 0; core_req = 0;
      $display("[TB] timeout done");
   endtask

   task automatic test_ack_err();
      idle_inputs();
      step(); dbg_req = 1; dbg_addr = 32'h400;
      step(); s_ack = 1; s_err = 1; s_rdata = 32'h1234;
      @(negedge clk);
      tests_run++; if ({dbg_ack, dbg_err, core_ack, core_err} !== 4'b0100 || dbg_rdata !== 32'h1234) begin
         tests_failed++; $display("FAIL ack_err got dack=%b derr=%b cack=%b cerr=%b rdata=%h exp 0/1/0/0/1234", dbg_ack, dbg_err, core_ack, core_err, dbg_rdata); end
      step(); s_ack = 0; s_err = 0; dbg_req = 0;
      $display("[TB] simultaneous ack+err done");
   endtask

   task automatic test_expiry_race();
      idle_inputs();
      step(); core_req = 1; core_addr = 32'h500;
      for (int k = 1; k < TO; k++) step();
      step(); s_ack = 1; s_rdata = 32'hCAFEF00D;
      @(negedge clk);
      tests_run++; if ({core_ack, core_err, timeout} !== 3'b100 || core_rdata !== 32'hCAFEF00D) begin
         tests_failed++; $display("FAIL race got ack=%b err=%b to=%b rdata=%h exp 1/0/0/cafef00d", core_ack, core_err, timeout, core_rdata); end
      step(); s_ack = 0; core_req = 0;
      @(negedge clk);
      tests_run++; if (s_req !== 1'b0 || timeout !== 1'b0) begin
         tests_failed++; $display("FAIL race_drop got req=%b to=%b exp 0/0", s_req, timeout); end
      $display("[TB] response in expiry cycle done");
   endtask

   task automatic test_reset_busy();
      idle_inputs();
      step(); dbg_req = 1; dbg_addr = 32'h300;
      step();
      @(negedge clk);
      tests_run++; if (s_req !== 1'b1 || owner_dbg !== 1'b1) begin
         tests_failed++; $display("FAIL rb_busy got req=%b odbg=%b exp 1/1", s_req, owner_dbg); end
      step(); rst = 1; s_ack = 1; s_rdata = 32'h5555;
      @(negedge clk);
      tests_run++; if ({core_ack, core_err, dbg_ack, dbg_err, timeout} !== 5'b0) begin
         tests_failed++; $display("FAIL rb_pulse got %b exp 00000", {core_ack, core_err, dbg_ack, dbg_err, timeout}); end
      step(); rst = 0; s_ack = 0; dbg_req = 0;
      @(negedge clk);
      tests_run++; if (s_req !== 1'b0 || dbg_ack !== 1'b0 || dbg_rdata !== 32'h0) begin
         tests_failed++; $display("FAIL rb_after got req=%b ack=%b rdata=%h exp 0/0/0", s_req, dbg_ack, dbg_rdata); end
      step(); core_req = 1; core_addr = 32'h310; dbg_req = 1; dbg_addr = 32'h320;
      step(); s_ack = 1;
      @(negedge clk);
      tests_run++; if (s_addr !== 32'h320 || dbg_ack !== 1'b1) begin
         tests_failed++; $display("FAIL rb_tie got addr=%h dack=%b exp 320/1", s_addr, dbg_ack); end
      step(); s_ack = 0; dbg_req = 0;
      step(); s_ack = 1;
      @(negedge clk);
      tests_run++; if (s_addr !== 32'h310 || core_ack !== 1'b1) begin
         tests_failed++; $display("FAIL rb_core got addr=%h cack=%b exp 310/1", s_addr, core_ack); end
      step(); s_ack = 0; core_req = 0;
      $display("[TB] reset during busy done");
   endtask

   task automatic test_random(input int n_cycles);
      bit          m_busy, m_owner, m_last, resp, exp_to, ce, de, win;
      int          m_age;
      logic        m_wr;
      logic [31:0] m_addr, m_wdata, m_crd, m_drd, exp_crd, exp_drd;
      logic [3:0]  m_be;
      logic [4:0]  exp_p;
      logic        p_creq, p_cwr, p_dreq, p_dwr, p_lock, p_ack, p_err;
      logic [31:0] p_caddr, p_cwdata, p_daddr, p_dwdata, p_rdata;
      logic [3:0]  p_cbe, p_dbe;
      int          r;
      idle_inputs();
      step(); rst = 1;
      step(); rst = 0;
      m_busy = 0; m_owner = 0; m_last = 0; m_age = 0; m_crd = 0; m_drd = 0;
      m_wr = 0; m_addr = 0; m_wdata = 0; m_be = 0;
      p_creq = 0; p_cwr = 0; p_caddr = 0; p_cwdata = 0; p_cbe = 0;
      p_dreq = 0; p_dwr = 0; p_daddr = 0; p_dwdata = 0; p_dbe = 0;
      p_lock = 0; p_ack = 0; p_err = 0; p_rdata = 0;
      for (int c = 0; c < n_cycles; c++) begin
         if (c > 0) step();
         core_req = p_creq; core_wr = p_cwr; core_addr = p_caddr; core_wdata = p_cwdata; core_be = p_cbe;
         dbg_req = p_dreq; dbg_wr = p_dwr; dbg_addr = p_daddr; dbg_wdata = p_dwdata; dbg_be = p_dbe;
         dbg_lock = p_lock; s_ack = p_ack; s_err = p_err; s_rdata = p_rdata;
         @(negedge clk);
         resp   = m_busy && (s_ack || s_err);
         exp_to = m_busy && !resp && (m_age == TO);
         exp_p  = {m_busy && !m_owner && s_ack && !s_err,
                   m_busy && !m_owner && (s_err || exp_to),
                   m_busy &&  m_owner && s_ack && !s_err,
                   m_busy &&  m_owner && (s_err || exp_to),
                   exp_to};
         exp_crd = (resp && !m_owner) ? s_rdata : m_crd;
         exp_drd = (resp &&  m_owner) ? s_rdata : m_drd;
         tests_run++; if (s_req !== m_busy) begin
            tests_failed++; $display("FAIL rnd_s_req cyc=%0d got=%b exp=%b", c, s_req, m_busy); end
         if (m_busy) begin
            tests_run++; if ({s_wr, s_addr, s_wdata, s_be} !== {m_wr, m_addr, m_wdata, m_be}) begin
               tests_failed++; $display("FAIL rnd_s_fields cyc=%0d got %b/%h/%h/%h exp %b/%h/%h/%h", c, s_wr, s_addr, s_wdata, s_be, m_wr, m_addr, m_wdata, m_be); end
         end
         tests_run++; if ({core_ack, core_err, dbg_ack, dbg_err, timeout} !== exp_p) begin
            tests_failed++; $display("FAIL rnd_pulses cyc=%0d got=%b exp=%b", c, {core_ack, core_err, dbg_ack, dbg_err, timeout}, exp_p); end
         tests_run++; if (core_rdata !== exp_crd || dbg_rdata !== exp_drd) begin
            tests_failed++; $display("FAIL rnd_rdata cyc=%0d got %h/%h exp %h/%h", c, core_rdata, dbg_rdata, exp_crd, exp_drd); end
         tests_run++; if (owner_dbg !== ((m_busy && m_owner) || (dbg_lock && m_last))) begin
            tests_failed++; $display("FAIL rnd_owner_dbg cyc=%0d got=%b", c, owner_dbg); end
         // Advance the transaction model by one bus cycle.
         if (m_busy) begin
            if (resp || exp_to) begin
               $display("[TB] rnd txn %s addr=%h wr=%b -> %s", m_owner ? "dbg" : "core", m_addr, m_wr,
                        exp_to ? "timeout" : (s_err ? "err" : "ack"));
               m_crd = exp_crd; m_drd = exp_drd; m_busy = 0; m_age = 0;
            end else begin
               m_age++;
            end
         end else begin
            ce = core_req && !(dbg_lock && m_last);
            de = dbg_req;
            if (ce || de) begin
               win = (ce && de) ? !m_last : de;
               m_wr    = win ? dbg_wr    : core_wr;
               m_addr  = win ? dbg_addr  : core_addr;
               m_wdata = win ? dbg_wdata : core_wdata;
               m_be    = win ? dbg_be    : core_be;
               m_busy = 1; m_owner = win; m_last = win; m_age = 1;
            end
         end
         // Plan next-cycle stimulus for masters and slave.
         if (exp_p[4] || exp_p[3]) p_creq = 0;
         else if (!p_creq && $urandom_range(0, 3) == 0) begin
            p_creq = 1; p_cwr = 1'($urandom_range(0, 1)); p_caddr = $urandom; p_cwdata = $urandom; p_cbe = 4'($urandom);
         end
         if (exp_p[2] || exp_p[1]) p_dreq = 0;
         else if (!p_dreq && $urandom_range(0, 3) == 0) begin
            p_dreq = 1; p_dwr = 1'($urandom_range(0, 1)); p_daddr = $urandom; p_dwdata = $urandom; p_dbe = 4'($urandom);
         end
         if ($urandom_range(0, 15) == 0) p_lock = ~p_lock;
         p_rdata = $urandom;
         p_ack = 0; p_err = 0;
         if (m_busy) begin
            r = int'($urandom_range(0, 9));
            if (m_age == TO && r < 5) p_ack = 1;
            else begin
               p_ack = (r <= 2);
               p_err = (r == 2) || (r == 3);
            end
         end
      end
      step(); idle_inputs();
   endtask

   initial begin
      rst = 1;
      test_reset();
      test_round_robin();
      test_core_read();
      test_lock();
      test_timeout();
      test_ack_err();
      test_expiry_race();
      test_reset_busy();
      test_random(800);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
